lzc_norm_pipe: RTL and testbench

LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

---
 rtl/lzc_norm_pipe.sv | 171 +++++++++++++++++
 tb/tb_lzc_norm_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// ----------------------------------------------------------------------------
// lzc_norm_pipe
// Two-stage pipelined leading/trailing bit counter with operand normalisation.
//
// Stage 1 captures the operand, mode and tag, and computes the count.
// Stage 2 produces the normalised operand.
// Normalisation shifts left for leading counts and right for trailing counts.
// Both stages use a valid/ready handshake. Stage 2 drives the outputs directly.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   operand can be accepted this cycle (combinational)
//   in_data    operand, DATA_WIDTH bits
//   in_mode    00 lead zeros, 01 lead ones, 10 trail zeros, 11 as 00
//   in_tag     sideband tag, returned unchanged
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_count  counted bits, saturates at DATA_WIDTH
//   out_all    no terminating bit found in the operand
//   out_norm   normalised operand (zero when out_all)
//   out_tag    tag of the operand
// ----------------------------------------------------------------------------
module lzc_norm_pipe #(
    parameter int DATA_WIDTH  = 22,
    parameter int COUNT_WIDTH = 5,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [1:0]             in_mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_all,
    output logic [DATA_WIDTH-1:0]  out_norm,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    // The count must be able to represent DATA_WIDTH itself (the saturated case).
    if ((64'd1 << COUNT_WIDTH) <= 64'(DATA_WIDTH)) begin : g_bad_count_width
        $error("lzc_norm_pipe: COUNT_WIDTH too small for DATA_WIDTH");
    end

    // Count of zeros from the MSB. A vector of all zeros yields DATA_WIDTH.
    function automatic logic [COUNT_WIDTH-1:0] lead_zeros(input logic [DATA_WIDTH-1:0] x);
        logic [COUNT_WIDTH-1:0] c;
        c = COUNT_WIDTH'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (x[i]) begin
                c = COUNT_WIDTH'(DATA_WIDTH - 1 - i);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = x[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    logic                   s1_valid_r;
    logic [DATA_WIDTH-1:0]  s1_data_r;
    logic [1:0]             s1_mode_r;
    logic [TAG_WIDTH-1:0]   s1_tag_r;
    logic [COUNT_WIDTH-1:0] s1_count_r;
    logic                   s1_all_r;

    logic                   s2_valid_r;
    logic [COUNT_WIDTH-1:0] s2_count_r;
    logic                   s2_all_r;
    logic [DATA_WIDTH-1:0]  s2_norm_r;
    logic [TAG_WIDTH-1:0]   s2_tag_r;

    logic                   s1_load_s;
    logic                   s2_load_s;
    logic [1:0]             mode_eff_s;
    logic [DATA_WIDTH-1:0]  scan_s;
    logic [COUNT_WIDTH-1:0] count_s;
    logic                   all_s;
    logic [DATA_WIDTH-1:0]  norm_s;

    // Handshake. Stage 1 may load whenever stage 2 can take its current content.
    always_comb begin
        s2_load_s = !s2_valid_r || out_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
        in_ready  = !s1_valid_r || !s2_valid_r || out_ready;
    end

    // Map every mode onto a leading-zero count of a transformed operand.
    always_comb begin
        mode_eff_s = (in_mode == 2'b11) ? 2'b00 : in_mode;
        case (mode_eff_s)
            2'b00:   scan_s = in_data;
            2'b01:   scan_s = ~in_data;
            2'b10:   scan_s = bit_reverse(in_data);
            default: scan_s = in_data;
        endcase
        count_s = lead_zeros(scan_s);
        all_s   = (scan_s == {DATA_WIDTH{1'b0}});
    end

    // Stage 1 register: operand, effective mode, tag and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_mode_r  <= 2'b00;
            s1_tag_r   <= '0;
            s1_count_r <= '0;
            s1_all_r   <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r  <= in_data;
                s1_mode_r  <= mode_eff_s;
                s1_tag_r   <= in_tag;
                s1_count_r <= count_s;
                s1_all_r   <= all_s;
            end
        end
    end

    // Normalisation. The all-match case is forced to zero rather than relying on the shift.
    always_comb begin
        norm_s = '0;
        if (s1_all_r) begin
            norm_s = '0;
        end else if (s1_mode_r == 2'b10) begin
            norm_s = s1_data_r >> s1_count_r;
        end else begin
            norm_s = s1_data_r << s1_count_r;
        end
    end

    // Stage 2 register: holds the result until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_count_r <= '0;
            s2_all_r   <= 1'b0;
            s2_norm_r  <= '0;
            s2_tag_r   <= '0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_count_r <= s1_count_r;
                s2_all_r   <= s1_all_r;
                s2_norm_r  <= norm_s;
                s2_tag_r   <= s1_tag_r;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign out_count = s2_count_r;
    assign out_all   = s2_all_r;
    assign out_norm  = s2_norm_r;
    assign out_tag   = s2_tag_r;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// ----------------------------------------------------------------------------
// tb_lzc_norm_pipe
// Self-checking bench for lzc_norm_pipe (DATA_WIDTH=22, COUNT_WIDTH=5, TAG_WIDTH=4).
//
// Each accepted operand pushes its expected result onto a queue.
// A monitor pops one entry and compares it on every output transfer.
// The monitor also checks that the outputs hold stable while stalled.
// ----------------------------------------------------------------------------
module tb_lzc_norm_pipe;

    localparam int DW = 22;
    localparam int CW = 5;
    localparam int TW = 4;

    typedef struct packed {
        logic [CW-1:0] count;
        logic          all;
        logic [DW-1:0] norm;
        logic [TW-1:0] tag;
    } res_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    m;
        logic [TW-1:0] t;
        res_t          r;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_mode = 2'b00;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_count;
    logic          out_all;
    logic [DW-1:0] out_norm;
    logic [TW-1:0] out_tag;

    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
    res_t exp_q[$];
    bit   hold_v = 1'b0;
    logic [DW+CW+TW+1:0] hold_val;
    vec_t vec[12];

    lzc_norm_pipe #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_all(out_all), .out_norm(out_norm), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference: scan bit by bit for the first terminating bit.
    function automatic res_t model(logic [DW-1:0] d, logic [1:0] m, logic [TW-1:0] t);
        res_t r;
        int   n;
        logic tgt;
        n = 0;
        if (m == 2'b10) begin
            while (n < DW && d[n] == 1'b0) n++;
        end else begin
            tgt = (m == 2'b01);
            while (n < DW && d[DW-1-n] == tgt) n++;
        end
        r.count = CW'(n);
        r.all   = (n == DW);
        if (r.all) r.norm = '0;
        else if (m == 2'b10) r.norm = d >> n;
        else r.norm = d << n;
        r.tag = t;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [1:0] m,
                        input logic [TW-1:0] t, input res_t e);
        int n;
        bit done;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
        n = 0; done = 1'b0;
        while (!done) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(posedge clk);
                n++;
                if (n > 1000) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: tag %0h not accepted in 1000 cycles", t);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Drive out_ready on the falling edge according to the current mode.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor and stall-stability check, sampled mid-cycle.
    always begin
        res_t got;
        res_t e;
        @(negedge clk);
        #2;
        got = {out_count, out_all, out_norm, out_tag};
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if ({out_valid, got} !== hold_val) begin
                    errors++;
                    $display("FAIL stall_hold: got %0h expected %0h", {out_valid, got}, hold_val);
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {out_valid, got};
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %0h with nothing expected", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL result: got cnt=%0d all=%0b norm=%06h tag=%0h expected cnt=%0d all=%0b norm=%06h tag=%0h",
                                 got.count, got.all, got.norm, got.tag, e.count, e.all, e.norm, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] r;
        int sh;
        logic [1:0] m;
        logic [TW-1:0] t;

        vec[0]  = '{d: 22'h000001, m: 2'b00, t: 4'h3, r: '{count: 5'd21, all: 1'b0, norm: 22'h200000, tag: 4'h3}};
        vec[1]  = '{d: 22'h000000, m: 2'b00, t: 4'h1, r: '{count: 5'd22, all: 1'b1, norm: 22'h000000, tag: 4'h1}};
        vec[2]  = '{d: 22'h000000, m: 2'b10, t: 4'h2, r: '{count: 5'd22, all: 1'b1, norm: 22'h000000, tag: 4'h2}};
        vec[3]  = '{d: 22'h3F0000, m: 2'b01, t: 4'h4, r: '{count: 5'd6,  all: 1'b0, norm: 22'h000000, tag: 4'h4}};
        vec[4]  = '{d: 22'h000100, m: 2'b10, t: 4'h5, r: '{count: 5'd8,  all: 1'b0, norm: 22'h000001, tag: 4'h5}};
        vec[5]  = '{d: 22'h0000FF, m: 2'b00, t: 4'h6, r: '{count: 5'd14, all: 1'b0, norm: 22'h3FC000, tag: 4'h6}};
        vec[6]  = '{d: 22'h000001, m: 2'b11, t: 4'h7, r: '{count: 5'd21, all: 1'b0, norm: 22'h200000, tag: 4'h7}};
        vec[7]  = '{d: 22'h3FFFFF, m: 2'b01, t: 4'h8, r: '{count: 5'd22, all: 1'b1, norm: 22'h000000, tag: 4'h8}};
        vec[8]  = '{d: 22'h200000, m: 2'b00, t: 4'h9, r: '{count: 5'd0,  all: 1'b0, norm: 22'h200000, tag: 4'h9}};
        vec[9]  = '{d: 22'h3FFFFF, m: 2'b00, t: 4'hA, r: '{count: 5'd0,  all: 1'b0, norm: 22'h3FFFFF, tag: 4'hA}};
        vec[10] = '{d: 22'h000001, m: 2'b10, t: 4'hB, r: '{count: 5'd0,  all: 1'b0, norm: 22'h000001, tag: 4'hB}};
        vec[11] = '{d: 22'h200000, m: 2'b10, t: 4'hC, r: '{count: 5'd21, all: 1'b0, norm: 22'h000001, tag: 4'hC}};

        // Reset state, held over two edges.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #15;
        chk("rst_outputs", 64'({out_count, out_all, out_norm, out_tag}), 64'd0);
        chk("rst_in_ready_held", 64'(in_ready), 64'd1);
        #5 rst_n = 1'b1;

        // First operand: accepted on the first edge, then latency check.
        send(vec[0].d, vec[0].m, vec[0].t, vec[0].r);
        @(negedge clk); #1;
        chk("latency_s1_only", 64'(out_valid), 64'd0);
        @(negedge clk); #1;
        chk("latency_s2_valid", 64'(out_valid), 64'd1);
        drain();

        // Directed table, back to back.
        for (int i = 0; i < 12; i++) begin
            send(vec[i].d, vec[i].m, vec[i].t, vec[i].r);
        end
        drain();

        // Stall: A and B fill the pipe, C and D wait, then all emerge in order.
        rdy_mode = 1;
        @(negedge clk);
        send(22'h000010, 2'b00, 4'hA, model(22'h000010, 2'b00, 4'hA));
        send(22'h3C0000, 2'b01, 4'hB, model(22'h3C0000, 2'b01, 4'hB));
        @(negedge clk); #1;
        chk("stall_in_ready_low", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_head_tag", 64'(out_tag), 64'hA);
        fork
            begin
                send(22'h000400, 2'b10, 4'hC, model(22'h000400, 2'b10, 4'hC));
                send(22'h000003, 2'b00, 4'hD, model(22'h000003, 2'b00, 4'hD));
            end
            begin
                repeat (4) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Asynchronous reset mid-cycle with two operands in flight.
        rdy_mode = 1;
        @(negedge clk);
        send(22'h000111, 2'b00, 4'h1, model(22'h000111, 2'b00, 4'h1));
        send(22'h000222, 2'b00, 4'h2, model(22'h000222, 2'b00, 4'h2));
        #2;
        rst_n = 1'b0;
        hold_v = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_outputs", 64'({out_count, out_all, out_norm, out_tag}), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        rdy_mode = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        send(22'h0000FF, 2'b00, 4'hE, '{count: 5'd14, all: 1'b0, norm: 22'h3FC000, tag: 4'hE});
        drain();

        // Random traffic with random backpressure across all modes.
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            r  = DW'($urandom);
            sh = $urandom_range(0, DW);
            m  = 2'($urandom_range(0, 3));
            t  = TW'(i);
            case ($urandom_range(0, 3))
                0:       r = r;
                1:       r = r >> sh;
                2:       r = ~(r >> sh);
                default: r = r << sh;
            endcase
            send(r, m, t, model(r, m, t));
        end
        rdy_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
